// File: rtl/inst_fetch_pkg.sv
// rtl/inst_fetch_pkg.sv - shared types and constants for the instruction fetch controller
package inst_fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } fetch_state_t;

    localparam int          OPCODE_W_DEF   = 4;
    localparam int          DATA_W_DEF     = 32;
    localparam logic [3:0]  END_OPCODE_DEF = 4'hF;

    // Opcode lives in the top bits of the instruction word.
    function automatic logic [OPCODE_W_DEF-1:0] get_opcode(input logic [DATA_W_DEF-1:0] inst);
        return inst[DATA_W_DEF-1 -: OPCODE_W_DEF];
    endfunction

endpackage

// File: rtl/inst_fetch_ctrl_fifo.sv
// rtl/inst_fetch_ctrl_fifo.sv - 2-entry skid FIFO carrying {addr, data} to the decoder
module fetch_skid_fifo #(
    parameter int W = 43
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    input  logic         flush_i,
    output logic [W-1:0] head_o,
    output logic [1:0]   count_o,
    output logic         empty_o,
    output logic         full_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   count_q;

    // Pointers and occupancy; flush behaves like reset for the control state.
    always_ff @(posedge clk) begin
        if (reset || flush_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_i) wr_ptr_q <= ~wr_ptr_q;
            if (pop_i)  rd_ptr_q <= ~rd_ptr_q;
            count_q <= count_q + {1'b0, push_i} - {1'b0, pop_i};
        end
    end

    // Payload storage needs no reset; occupancy qualifies it.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == 2'd0);
    assign full_o  = (count_q == 2'd2);

endmodule

// File: rtl/inst_fetch_ctrl.sv
// rtl/inst_fetch_ctrl.sv - sequences imem port-B reads and streams instructions to the decoder
module inst_fetch_ctrl
    import inst_fetch_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 11,
    parameter int                    OPCODE_W   = OPCODE_W_DEF,
    parameter logic [OPCODE_W-1:0]   END_OPCODE = END_OPCODE_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   inst_count,
    input  logic                  stop,
    output logic                  busy,
    output logic                  done,
    output logic                  imem_read_req,
    output logic [ADDR_WIDTH-1:0] imem_read_addr,
    input  logic [DATA_WIDTH-1:0] imem_read_data,
    output logic                  inst_valid,
    input  logic                  inst_ready,
    output logic [DATA_WIDTH-1:0] inst_data,
    output logic [ADDR_WIDTH-1:0] inst_addr
);

    localparam int CW = ADDR_WIDTH + 1;
    localparam int FW = ADDR_WIDTH + DATA_WIDTH;

    fetch_state_t state_q, state_d;

    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [CW-1:0]         issued_q, issued_d;
    logic [CW-1:0]         delivered_q, delivered_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  end_seen_q, end_seen_d;
    logic                  pending_q, pending_d;
    logic                  discard_q, discard_d;
    logic [ADDR_WIDTH-1:0] pend_addr_q, pend_addr_d;

    logic          fifo_empty_w, fifo_full_w;
    logic [1:0]    fifo_count_w;
    logic [FW-1:0] fifo_head_w;
    logic [2:0]    fill_w;
    logic          in_run_w, abort_w, pop_w, req_w, push_w, push_end_w;
    logic          head_end_w, last_issue_w, complete_w, start_go_w;

    assign in_run_w   = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign abort_w    = stop && in_run_w;
    assign pop_w      = !fifo_empty_w && inst_ready;
    // Words buffered plus the read in flight, after this cycle's pop.
    assign fill_w     = {1'b0, fifo_count_w} + {2'b00, pending_q} - {2'b00, pop_w};
    assign req_w      = (state_q == ST_FETCH) && (fill_w < 3'd2) && !stop && !end_seen_q;
    assign push_w     = pending_q && !discard_q && !abort_w && (!fifo_full_w || pop_w);
    assign push_end_w = push_w && (imem_read_data[DATA_WIDTH-1 -: OPCODE_W] == END_OPCODE);
    assign head_end_w = (fifo_head_w[DATA_WIDTH-1 -: OPCODE_W] == END_OPCODE);
    assign last_issue_w = req_w && ((issued_q + CW'(1)) == count_q);
    assign complete_w = pop_w && (((delivered_q + CW'(1)) == count_q) || head_end_w);
    assign start_go_w = (state_q == ST_IDLE) && start && (inst_count != '0);

    fetch_skid_fifo #(.W(FW)) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (push_w),
        .push_data_i ({pend_addr_q, imem_read_data}),
        .pop_i       (pop_w),
        .flush_i     (abort_w),
        .head_o      (fifo_head_w),
        .count_o     (fifo_count_w),
        .empty_o     (fifo_empty_w),
        .full_o      (fifo_full_w)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; abort outranks completion.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = (inst_count == '0) ? ST_DONE : ST_FETCH;
            end
            ST_FETCH: begin
                if (abort_w)           state_d = ST_IDLE;
                else if (complete_w)   state_d = ST_DONE;
                else if (last_issue_w) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (abort_w)         state_d = ST_IDLE;
                else if (complete_w) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and stream outputs.
    always_comb begin
        busy           = (state_q != ST_IDLE);
        done           = (state_q == ST_DONE);
        imem_read_req  = req_w;
        imem_read_addr = fetch_addr_q;
        inst_valid     = !fifo_empty_w;
        inst_addr      = fifo_head_w[FW-1 -: ADDR_WIDTH];
        inst_data      = fifo_head_w[DATA_WIDTH-1:0];
    end

    // Datapath next state: program load, issue/deliver counters, END tracking.
    always_comb begin
        fetch_addr_d = fetch_addr_q;
        issued_d     = issued_q;
        delivered_d  = delivered_q;
        count_d      = count_q;
        end_seen_d   = end_seen_q;
        if (start_go_w) begin
            fetch_addr_d = base_addr;
            issued_d     = '0;
            delivered_d  = '0;
            count_d      = inst_count;
            end_seen_d   = 1'b0;
        end else begin
            if (req_w) begin
                fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
                issued_d     = issued_q + CW'(1);
            end
            if (pop_w && !abort_w) delivered_d = delivered_q + CW'(1);
            if (push_end_w)        end_seen_d  = 1'b1;
        end
        pending_d   = req_w;
        pend_addr_d = req_w ? fetch_addr_q : pend_addr_q;
        // A read issued while END is being captured returns a word past the program end.
        discard_d   = req_w && push_end_w;
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_addr_q <= '0;
            issued_q     <= '0;
            delivered_q  <= '0;
            count_q      <= '0;
            end_seen_q   <= 1'b0;
            pending_q    <= 1'b0;
            discard_q    <= 1'b0;
            pend_addr_q  <= '0;
        end else begin
            fetch_addr_q <= fetch_addr_d;
            issued_q     <= issued_d;
            delivered_q  <= delivered_d;
            count_q      <= count_d;
            end_seen_q   <= end_seen_d;
            pending_q    <= pending_d;
            discard_q    <= discard_d;
            pend_addr_q  <= pend_addr_d;
        end
    end

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// tb/tb_inst_fetch_ctrl.sv - directed scoreboard bench for inst_fetch_ctrl
module tb_inst_fetch_ctrl;

    localparam int DW = 32;
    localparam int AW = 11;

    logic          clk = 1'b0;
    logic          reset, start, stop, inst_ready;
    logic [AW-1:0] base_addr;
    logic [AW:0]   inst_count;
    logic          busy, done, imem_read_req, inst_valid;
    logic [AW-1:0] imem_read_addr, inst_addr;
    logic [DW-1:0] imem_read_data, inst_data;

    logic [31:0]   mem [0:2047];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    logic [42:0] sb[$];
    int exp_rd[$];
    int reads_seen, pops, dones, first_valid_cyc, last_pop_cyc, done_cyc;
    bit hold_pend, chk_reads;
    logic [42:0] held;

    inst_fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .base_addr      (base_addr),
        .inst_count     (inst_count),
        .stop           (stop),
        .busy           (busy),
        .done           (done),
        .imem_read_req  (imem_read_req),
        .imem_read_addr (imem_read_addr),
        .imem_read_data (imem_read_data),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_data      (inst_data),
        .inst_addr      (inst_addr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_read_req) imem_read_data <= mem[imem_read_addr];
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fail_now(input string tag, input logic [63:0] obs);
        checks++;
        failures++;
        $error("FAIL %s observed=0x%0h expected=none", tag, obs);
    endtask

    task automatic observe();
        if (imem_read_req) begin
            reads_seen++;
            if (chk_reads) begin
                if (exp_rd.size() == 0) fail_now("rd_extra", 64'(imem_read_addr));
                else chk("rd_addr", 64'(imem_read_addr), 64'(exp_rd.pop_front()));
            end
        end
        if (hold_pend) chk("hold_stable", {inst_valid, inst_addr, inst_data}, {1'b1, held});
        if (inst_valid && inst_ready) begin
            pops++;
            last_pop_cyc = cyc;
            if (sb.size() == 0) fail_now("word_extra", {inst_addr, inst_data});
            else chk("word", {inst_addr, inst_data}, sb.pop_front());
        end
        hold_pend = inst_valid && !inst_ready;
        held = {inst_addr, inst_data};
        if (inst_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (done) begin
            dones++;
            done_cyc = cyc;
        end
        if (chk_reads) chk("buffered_le2", 64'((reads_seen - pops) <= 2), 64'd1);
    endtask

    task automatic step();
        @(negedge clk);
        observe();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic init_run(input bit creads);
        reads_seen = 0; pops = 0; dones = 0;
        first_valid_cyc = -1; last_pop_cyc = -1; done_cyc = -1;
        hold_pend = 1'b0; chk_reads = creads; cyc = 0;
        sb.delete(); exp_rd.delete();
    endtask

    task automatic run(input int base, input int cnt, input int mode, input bit creads);
        int a;
        logic [31:0] w;
        init_run(creads);
        a = base;
        for (int i = 0; i < cnt; i++) begin
            w = mem[a];
            sb.push_back({a[10:0], w});
            if (creads) exp_rd.push_back(a);
            if (w[31:28] == 4'hF) break;
            a = (a + 1) % 2048;
        end
        base_addr = AW'(base);
        inst_count = (AW+1)'(cnt);
        start = 1'b1;
        inst_ready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 200; k++) begin
            inst_ready = (mode == 0) || (cyc % 3 == 1);
            step();
            if (dones != 0) break;
        end
        chk("done_once", 64'(dones), 64'd1);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        chk("busy_after", 64'(busy), 64'd0);
        chk("done_after_pop", 64'(done_cyc), 64'(last_pop_cyc + 1));
        chk("first_valid_lat", 64'(first_valid_cyc), 64'd3);
        if (creads) chk("rd_all_issued", 64'(exp_rd.size()), 64'd0);
        step();
        step();
        chk("no_extra_done", 64'(dones), 64'd1);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0100_0000 + i;
        for (int i = 0; i < 4; i++) mem[10+i] = 32'h1000_0001 + i;
        mem[20] = 32'h1000_0005;
        mem[21] = 32'hF000_0000;
        mem[22] = 32'h2000_0000;

        reset = 1'b1; start = 1'b0; stop = 1'b0; inst_ready = 1'b0;
        base_addr = '0; inst_count = '0;
        init_run(1'b0);
        @(posedge clk); #1;
        step();
        step();
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_req", 64'(imem_read_req), 64'd0);
        chk("rst_valid", 64'(inst_valid), 64'd0);
        reset = 1'b0;
        step();

        run(10, 4, 0, 1'b1);
        run(10, 4, 1, 1'b1);
        run(20, 8, 0, 1'b0);
        chk("end_pops", 64'(pops), 64'd2);
        run(20, 2, 0, 1'b1);
        run(2046, 4, 0, 1'b1);

        init_run(1'b1);
        base_addr = AW'(5); inst_count = '0; start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("zero_done_once", 64'(dones), 64'd1);
        chk("zero_no_reads", 64'(reads_seen), 64'd0);
        chk("zero_done_window", 64'(done_cyc >= 1 && done_cyc <= 2), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);

        init_run(1'b0);
        sb.push_back({11'd0, mem[0]});
        sb.push_back({11'd1, mem[1]});
        base_addr = '0; inst_count = 12'd16; start = 1'b1; inst_ready = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();
        chk("abort_inflight", 64'(dut.pending_q), 64'd1);
        stop = 1'b1; inst_ready = 1'b0;
        step();
        stop = 1'b0; hold_pend = 1'b0;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_valid", 64'(inst_valid), 64'd0);
        chk("abort_req", 64'(imem_read_req), 64'd0);
        for (int k = 0; k < 3; k++) step();
        chk("abort_no_done", 64'(dones), 64'd0);
        chk("abort_sb", 64'(sb.size()), 64'd0);
        run(100, 1, 0, 1'b1);

        init_run(1'b1);
        for (int i = 0; i < 4; i++) exp_rd.push_back(i);
        sb.push_back({11'd0, mem[0]});
        sb.push_back({11'd1, mem[1]});
        base_addr = '0; inst_count = 12'd16; start = 1'b1; inst_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        start = 1'b1; base_addr = AW'(500); inst_count = 12'd3;
        step();
        start = 1'b0;
        step();
        reset = 1'b1;
        step();
        reset = 1'b0; hold_pend = 1'b0; chk_reads = 1'b0;
        chk("mrst_busy", 64'(busy), 64'd0);
        chk("mrst_valid", 64'(inst_valid), 64'd0);
        chk("mrst_req", 64'(imem_read_req), 64'd0);
        chk("mrst_reads", 64'(exp_rd.size()), 64'd0);
        chk("mrst_words", 64'(sb.size()), 64'd0);
        step();
        step();
        chk("mrst_no_done", 64'(dones), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
